// File: rtl/gpmc_target_if.sv
// rtl/gpmc_target_if.sv - muxed 16-bit GPMC pin bundle between host pins and the target
//
// Purpose: groups the GPMC address/data and control pins.
// The master side is the host or pin model. The slave side is gpmc_target.
// Signals:
//   gpmc_ad_in   16  AD bus sampled value
//   gpmc_ad_out  16  AD bus drive value
//   gpmc_ad_oe   1   AD bus output enable (the top level does the tristate)
//   gpmc_advn    1   address valid, active low
//   gpmc_csn     1   chip select, active low
//   gpmc_wein    1   write enable, active low
//   gpmc_oen     1   output enable, active low
interface gpmc_target_if;
  logic [15:0] gpmc_ad_in;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic        gpmc_advn;
  logic        gpmc_csn;
  logic        gpmc_wein;
  logic        gpmc_oen;

  modport master (
    output gpmc_ad_in, gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen,
    input  gpmc_ad_out, gpmc_ad_oe
  );

  modport slave (
    input  gpmc_ad_in, gpmc_advn, gpmc_csn, gpmc_wein, gpmc_oen,
    output gpmc_ad_out, gpmc_ad_oe
  );
endinterface

// File: rtl/gpmc_target.sv
// rtl/gpmc_target.sv - GPMC muxed-bus responder issuing register strobes and pixel FIFO pushes
//
// Purpose: decodes GPMC address and data phases in the gpmc_clk domain.
// It issues one-cycle register read and write strobes.
// Writes that fall in the pixel window go to the pixel FIFO instead of the register file.
// The optional macro GPMC_TARGET_BURST_EN enables burst data phases with an auto-incremented address.
// Ports:
//   gpmc_clk     in   bus clock, rising edge
//   gpmc_resetn  in   async active-low reset
//   bus          slave modport of gpmc_target_if (AD bus, advn, csn, wein, oen, ad_oe)
//   reg_addr     out  latched word address
//   reg_wr_en    out  one-cycle register write strobe
//   reg_wr_data  out  write data, valid with reg_wr_en / fifo_wr_en
//   reg_rd_en    out  one-cycle register read strobe
//   reg_rd_data  in   read data, valid RD_LAT cycles after reg_rd_en
//   fifo_wr_en   out  one-cycle pixel FIFO push
//   fifo_full    in   pixel FIFO full
//   drop_cnt     out  saturating count of pushes dropped on fifo_full
module gpmc_target #(
  parameter int                ADDR_W    = 16,
  parameter int                RD_LAT    = 1,
  parameter logic [ADDR_W-1:0] FIFO_BASE = ADDR_W'(16'h0800),
  parameter logic [ADDR_W-1:0] FIFO_MASK = ADDR_W'(16'hF800)
) (
  input  logic              gpmc_clk,
  input  logic              gpmc_resetn,
  gpmc_target_if.slave      bus,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [15:0]       reg_wr_data,
  output logic              reg_rd_en,
  input  logic [15:0]       reg_rd_data,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_WAIT_CS = 3'd4
  } state_t;

  state_t state, state_d;

  logic              csn, advn, wein, oen;
  logic [15:0]       ad_in;

  logic [15:0]       cap_data;   // data word captured on the bus, waiting for its strobe
  logic              pend;       // a captured word still owes its strobe
  logic [15:0]       rd_hold;    // value driven onto the AD bus during reads
  logic              ad_oe_q;
  logic [RD_LAT-1:0] rd_pipe;    // tracks reg_rd_en until reg_rd_data is valid

  logic              addr_cap, data_cap, wr_fire, rd_fire, rd_zero, addr_inc, oe_d;
  logic [ADDR_W-1:0] addr_plus, wr_addr;
  logic              window_hit;

`ifdef GPMC_TARGET_BURST_EN
  logic              first;      // next write strobe uses the latched address unchanged
`endif

  assign csn   = bus.gpmc_csn;
  assign advn  = bus.gpmc_advn;
  assign wein  = bus.gpmc_wein;
  assign oen   = bus.gpmc_oen;
  assign ad_in = bus.gpmc_ad_in;

  assign bus.gpmc_ad_out = rd_hold;
  assign bus.gpmc_ad_oe  = ad_oe_q;

  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return (a & FIFO_MASK) == FIFO_BASE;
  endfunction

  assign addr_plus  = reg_addr + ADDR_W'(1);
  // Burst strobes after the first one target the following word.
  assign wr_addr    = addr_inc ? addr_plus : reg_addr;
  assign window_hit = in_window(wr_addr);

  // State register
  always_ff @(posedge gpmc_clk or negedge gpmc_resetn) begin
    if (!gpmc_resetn) state <= S_IDLE;
    else              state <= state_d;
  end

  // Next-state logic; csn high returns to IDLE from anywhere
  always_comb begin
    state_d = state;
    if (csn) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (!advn) state_d = S_ADDR;
        S_ADDR: begin
          if (advn) begin
            if (!wein)     state_d = S_WRITE;
            else if (!oen) state_d = S_READ;
          end
        end
`ifdef GPMC_TARGET_BURST_EN
        S_WRITE:   state_d = S_WRITE;
        S_READ:    state_d = S_READ;
`else
        S_WRITE:   state_d = S_WAIT_CS;
        S_READ:    if (oen) state_d = S_WAIT_CS;
`endif
        S_WAIT_CS: state_d = S_WAIT_CS;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Per-edge control decode driving the datapath registers below
  always_comb begin
    addr_cap = 1'b0;
    data_cap = 1'b0;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    rd_zero  = 1'b0;
    addr_inc = 1'b0;
    oe_d     = 1'b0;
    if (!csn) begin
      case (state)
        S_IDLE: addr_cap = !advn;
        S_ADDR: begin
          if (!advn) begin
            addr_cap = 1'b1;
          end else if (!wein) begin
            // When wein and oen are both low, the write wins.
            data_cap = 1'b1;
          end else if (!oen) begin
            oe_d = 1'b1;
            // Pixel window reads return zero without disturbing the register file.
            if (in_window(reg_addr)) rd_zero = 1'b1;
            else                     rd_fire = 1'b1;
          end
        end
        S_WRITE: begin
          wr_fire = pend;
`ifdef GPMC_TARGET_BURST_EN
          data_cap = !wein;
          addr_inc = pend && !first;
`endif
        end
        S_READ: begin
          oe_d = !oen;
`ifdef GPMC_TARGET_BURST_EN
          // On the end of each oen pulse, prefetch the next word for the following pulse.
          if (oen && ad_oe_q) begin
            addr_inc = 1'b1;
            if (in_window(addr_plus)) rd_zero = 1'b1;
            else                      rd_fire = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath and strobe registers
  always_ff @(posedge gpmc_clk or negedge gpmc_resetn) begin
    if (!gpmc_resetn) begin
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      fifo_wr_en  <= 1'b0;
      drop_cnt    <= '0;
      cap_data    <= '0;
      pend        <= 1'b0;
      rd_hold     <= '0;
      ad_oe_q     <= 1'b0;
      rd_pipe     <= '0;
`ifdef GPMC_TARGET_BURST_EN
      first       <= 1'b0;
`endif
    end else begin
      reg_wr_en  <= 1'b0;
      fifo_wr_en <= 1'b0;
      reg_rd_en  <= rd_fire;
      ad_oe_q    <= oe_d;

      if (csn) rd_pipe <= '0;
      else     rd_pipe <= RD_LAT'({rd_pipe, reg_rd_en});

      if (addr_cap)      reg_addr <= ADDR_W'(ad_in);
      else if (addr_inc) reg_addr <= addr_plus;

      if (data_cap) cap_data <= ad_in;

      if (data_cap)            pend <= 1'b1;
      else if (wr_fire || csn) pend <= 1'b0;

`ifdef GPMC_TARGET_BURST_EN
      if (state == S_ADDR) first <= 1'b1;
      else if (wr_fire)    first <= 1'b0;
`endif

      if (wr_fire) begin
        reg_wr_data <= cap_data;
        if (window_hit) begin
          if (fifo_full) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            fifo_wr_en <= 1'b1;
          end
        end else begin
          reg_wr_en <= 1'b1;
        end
      end

      if (rd_pipe[RD_LAT-1]) rd_hold <= reg_rd_data;
      else if (rd_zero)      rd_hold <= '0;
    end
  end

endmodule

// File: tb/tb_gpmc_target.sv
// tb/tb_gpmc_target.sv - directed and randomized bench for gpmc_target against a word-level reference model
module tb_gpmc_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] reg_addr, reg_wr_data, reg_rd_data;
  logic        reg_wr_en, reg_rd_en, fifo_wr_en, fifo_full;
  logic [7:0]  drop_cnt;

  gpmc_target_if bus();

  gpmc_target dut (
    .gpmc_clk    (clk),
    .gpmc_resetn (resetn),
    .bus         (bus),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .drop_cnt    (drop_cnt)
  );

  // Register file responder with one cycle of read latency
  logic [15:0] regfile [0:63];
  always @(posedge clk) begin
    if (reg_wr_en) regfile[reg_addr[5:0]] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= regfile[reg_addr[5:0]];
  end

  // Strobe monitor
  int          wr_cnt = 0, fifo_cnt = 0, rd_cnt = 0, rd_dbl = 0;
  logic        prev_rd = 1'b0;
  logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0;
  logic [15:0] fifo_log [0:255];
  always @(posedge clk) begin
    if (reg_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= reg_addr;
      last_wr_data <= reg_wr_data;
    end
    if (fifo_wr_en) begin
      fifo_log[fifo_cnt[7:0]] <= reg_wr_data;
      fifo_cnt <= fifo_cnt + 1;
    end
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (reg_rd_en && prev_rd) rd_dbl <= rd_dbl + 1;
    prev_rd <= reg_rd_en;
  end

  // Reference model: word storage, expected FIFO contents, dropped pushes
  logic [15:0] ref_mem [0:63];
  logic [15:0] ref_fifo [$];
  int          ref_drop = 0;
  int          passed = 0, total = 0;

  function automatic logic in_win(input logic [15:0] a);
    return (a & 16'hF800) == 16'h0800;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic c, input logic a, input logic w, input logic o, input logic [15:0] d);
    bus.gpmc_csn   = c;
    bus.gpmc_advn  = a;
    bus.gpmc_wein  = w;
    bus.gpmc_oen   = o;
    bus.gpmc_ad_in = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic full);
    fifo_full = full;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, addr);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, data);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, data);
    idle();
    fifo_full = 1'b0;
    if (in_win(addr)) begin
      if (full) ref_drop = (ref_drop == 255) ? 255 : ref_drop + 1;
      else      ref_fifo.push_back(data);
    end else begin
      ref_mem[addr[5:0]] = data;
    end
  endtask

  task automatic check_read(input string tag, input logic [15:0] addr);
    logic [15:0] exp, seen;
    logic        oe_on, oe_off;
    int          r0;
    exp = in_win(addr) ? 16'h0000 : ref_mem[addr[5:0]];
    r0  = rd_cnt;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, addr);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    seen  = bus.gpmc_ad_out;
    oe_on = bus.gpmc_ad_oe;
    chk({tag, "_rd_en_cnt"}, 16'(rd_cnt - r0), in_win(addr) ? 16'd0 : 16'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    oe_off = bus.gpmc_ad_oe;
    idle();
    chk({tag, "_data"}, seen, exp);
    chk({tag, "_oe_on"}, 16'(oe_on), 16'd1);
    chk({tag, "_oe_off"}, 16'(oe_off), 16'd0);
  endtask

  initial begin
    int w0, f0, r0;
    logic [15:0] d0, d1, d2, d3, a;

    resetn    = 1'b0;
    fifo_full = 1'b0;
    bus.gpmc_csn = 1'b1; bus.gpmc_advn = 1'b1; bus.gpmc_wein = 1'b1;
    bus.gpmc_oen = 1'b1; bus.gpmc_ad_in = 16'h0;
    repeat (3) @(negedge clk);

    chk("rst_oe",      16'(bus.gpmc_ad_oe), 16'd0);
    chk("rst_ad_out",  bus.gpmc_ad_out,     16'h0);
    chk("rst_addr",    reg_addr,            16'h0);
    chk("rst_wr_data", reg_wr_data,         16'h0);
    chk("rst_strobes", {13'd0, reg_wr_en, reg_rd_en, fifo_wr_en}, 16'h0);
    chk("rst_drop",    16'(drop_cnt),       16'h0);
    resetn = 1'b1;
    idle();

    // Write byte 0x0002 -> word 0x0001
    w0 = wr_cnt; f0 = fifo_cnt;
    do_write(16'h0001, 16'h4321, 1'b0);
    chk("wr1_cnt",  16'(wr_cnt - w0),   16'd1);
    chk("wr1_addr", last_wr_addr,       16'h0001);
    chk("wr1_data", last_wr_data,       16'h4321);
    chk("wr1_fifo", 16'(fifo_cnt - f0), 16'd0);

    // Read word 0 holding 0xBEEF
    do_write(16'h0000, 16'hBEEF, 1'b0);
    check_read("rd_beef", 16'h0000);

    // Six pixel pushes, FIFO full during the third
    w0 = wr_cnt; f0 = fifo_cnt;
    for (int i = 0; i < 6; i++) do_write(16'h0800, 16'($urandom), i == 2);
    chk("px_push_cnt", 16'(fifo_cnt - f0), 16'd5);
    chk("px_drop",     16'(drop_cnt),      16'(ref_drop));
    chk("px_no_reg",   16'(wr_cnt - w0),   16'd0);

    // Chip select abort after the address phase, then after data capture
    w0 = wr_cnt; f0 = fifo_cnt; r0 = rd_cnt;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h000A);
    idle(); idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h000A);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777);
    idle(); idle();
    chk("abort_strobes", 16'((wr_cnt - w0) + (fifo_cnt - f0) + (rd_cnt - r0)), 16'd0);
    w0 = wr_cnt;
    do_write(16'h000A, 16'h0001, 1'b0);
    chk("after_abort_cnt",  16'(wr_cnt - w0), 16'd1);
    chk("after_abort_addr", last_wr_addr,     16'h000A);
    check_read("after_abort_rd", 16'h000A);

    // Address recaptured while advn is pulsed again
    d0 = 16'($urandom);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0003);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0007);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, d0);
    idle();
    ref_mem[7] = d0;
    chk("recap_addr", last_wr_addr, 16'h0007);

    // wein and oen low together: write wins
    w0 = wr_cnt; r0 = rd_cnt; d1 = 16'($urandom);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0009);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, d1);
    chk("both_low_oe", 16'(bus.gpmc_ad_oe), 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, d1);
    idle();
    ref_mem[9] = d1;
    chk("both_low_wr", 16'(wr_cnt - w0), 16'd1);
    chk("both_low_rd", 16'(rd_cnt - r0), 16'd0);
    chk("both_low_data", last_wr_data, d1);

`ifndef GPMC_TARGET_BURST_EN
    // Extra data phases after the first are ignored
    w0 = wr_cnt; d0 = 16'($urandom); d1 = ~d0; d2 = d0 ^ 16'h00FF;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, d2);
    idle();
    ref_mem[5] = d0;
    chk("extra_phase_cnt",  16'(wr_cnt - w0), 16'd1);
    chk("extra_phase_data", last_wr_data,     d0);
`endif

    // Fill all modelled registers, then randomized traffic
    for (int i = 0; i < 64; i++) do_write(16'(i), 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 16'h0800 + 16'($urandom_range(0, 7));
      else                           a = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0)
        do_write(a, 16'($urandom), in_win(a) && ($urandom_range(0, 2) == 0));
      else
        check_read("rnd_rd", a);
    end
    chk("rnd_drop", 16'(drop_cnt), 16'(ref_drop));

`ifdef GPMC_TARGET_BURST_EN
    // Four-word burst into the pixel window
    d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0800);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    idle();
    ref_fifo.push_back(d0); ref_fifo.push_back(d1);
    ref_fifo.push_back(d2); ref_fifo.push_back(d3);

    // Burst wrapping past the top of the address space
    w0 = wr_cnt; d0 = 16'($urandom); d1 = 16'($urandom);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    idle();
    ref_mem[0] = d1;
    chk("burst_wrap_cnt",  16'(wr_cnt - w0), 16'd2);
    chk("burst_wrap_addr", last_wr_addr,     16'h0000);
    chk("burst_wrap_data", last_wr_data,     d1);
`endif

    // Everything pushed so far, in order
    chk("fifo_total", 16'(fifo_cnt), 16'(ref_fifo.size()));
    for (int i = 0; i < ref_fifo.size() && i < 256; i++)
      chk($sformatf("fifo_word%0d", i), fifo_log[i], ref_fifo[i]);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) do_write(16'h0800 + 16'(i % 8), 16'($urandom), 1'b1);
    chk("drop_sat", 16'(drop_cnt), 16'(ref_drop));
    chk("rd_no_double", 16'(rd_dbl), 16'd0);

    // Reset in the middle of a read data phase
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0001);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("pre_rst_oe", 16'(bus.gpmc_ad_oe), 16'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_oe",      16'(bus.gpmc_ad_oe), 16'd0);
    chk("async_rst_ad_out",  bus.gpmc_ad_out,     16'h0);
    chk("async_rst_addr",    reg_addr,            16'h0);
    chk("async_rst_drop",    16'(drop_cnt),       16'h0);
    chk("async_rst_strobes", {13'd0, reg_wr_en, reg_rd_en, fifo_wr_en}, 16'h0);
    @(negedge clk);
    idle();
    resetn = 1'b1;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
